// File: rtl/key_pkg.sv
// Shared constants and parameter sanity helpers for the key debounce bank.
package key_pkg;

    // 0.1 s stability window at the 100 MHz board clock.
    localparam int unsigned BOARD_STABLE_CYCLES = 10_000_000;

    // True when a w-bit unsigned counter can hold every value up to val.
    function automatic bit fits(input int unsigned w, input int unsigned val);
        if (w == 0) begin
            return 1'b0;
        end
        if (w >= 32) begin
            return 1'b1;
        end
        return (64'd1 << w) > 64'(val);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, stability filter, press/release strobes
// and optional auto-repeat strobe.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = BOARD_STABLE_CYCLES,
    parameter int unsigned CNT_W         = 24,
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter int unsigned REPEAT_CYCLES = 0,
    parameter int unsigned REP_W         = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rep
);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("key_debounce_ch: STABLE_CYCLES must be >= 1");
    end
    if (!fits(CNT_W, STABLE_CYCLES)) begin : g_bad_cnt_w
        $error("key_debounce_ch: CNT_W too narrow for STABLE_CYCLES");
    end
    if (REPEAT_CYCLES > 0 && !fits(REP_W, REPEAT_CYCLES)) begin : g_bad_rep_w
        $error("key_debounce_ch: REP_W too narrow for REPEAT_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             cand;
    logic [CNT_W-1:0] cnt;
    logic             commit_c;

    // Candidate has been stable for the full window and differs from the level.
    assign commit_c = (s2 == cand) && (cnt == CNT_LAST) && (level != cand);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cand  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1    <= raw ^ ACTIVE_LOW;
            s2    <= s1;
            press <= 1'b0;
            rel   <= 1'b0;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (commit_c) begin
                level <= cand;
                press <= cand;
                rel   <= ~cand;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    if (REPEAT_CYCLES > 0) begin : g_rep
        localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

        logic [REP_W-1:0] rcnt;

        // commit_c covers both the press cycle (restart) and the release cycle (no repeat).
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rcnt <= '0;
                rep  <= 1'b0;
            end else begin
                rep <= 1'b0;
                if (!level || commit_c) begin
                    rcnt <= '0;
                end else if (rcnt == REP_LAST) begin
                    rcnt <= '0;
                    rep  <= 1'b1;
                end else begin
                    rcnt <= rcnt + REP_W'(1);
                end
            end
        end
    end else begin : g_no_rep
        assign rep = 1'b0;
    end

endmodule

// File: rtl/key_debounce_bank.sv
// N_CH independent debounced key channels for the board-level CPU demo.
module key_debounce_bank
    import key_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = BOARD_STABLE_CYCLES,
    parameter int unsigned CNT_W         = 24,
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter int unsigned REPEAT_CYCLES = 0,
    parameter int unsigned REP_W         = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] key_i,
    output logic [N_CH-1:0] key_o,
    output logic [N_CH-1:0] key_press,
    output logic [N_CH-1:0] key_release,
    output logic [N_CH-1:0] key_rep
);

    if (N_CH < 1) begin : g_bad_n_ch
        $error("key_debounce_bank: N_CH must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        key_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REP_W         (REP_W)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (key_i[i]),
            .level (key_o[i]),
            .press (key_press[i]),
            .rel   (key_release[i]),
            .rep   (key_rep[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench: stimulus queues expected strobes, a negedge monitor matches them.
module tb_key_debounce_bank;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;
    localparam int REP_P   = 8;

    typedef struct {
        int cyc;
        int dut;
        int ch;
        int kind;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_a = 4'b0000;
    logic [3:0] key_o_a, press_a, rel_a, rep_a;
    logic [0:0] key_b = 1'b1;
    logic [0:0] key_o_b, press_b, rel_b, rep_b;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_debounce_bank #(
        .N_CH(4), .STABLE_CYCLES(4), .CNT_W(4), .ACTIVE_LOW(1'b0),
        .REPEAT_CYCLES(8), .REP_W(4)
    ) u_dut (
        .clk(clk), .rst(rst), .key_i(key_a), .key_o(key_o_a),
        .key_press(press_a), .key_release(rel_a), .key_rep(rep_a)
    );

    key_debounce_bank #(
        .N_CH(1), .STABLE_CYCLES(4), .CNT_W(4), .ACTIVE_LOW(1'b1),
        .REPEAT_CYCLES(0), .REP_W(4)
    ) u_dut_al (
        .clk(clk), .rst(rst), .key_i(key_b), .key_o(key_o_b),
        .key_press(press_b), .key_release(rel_b), .key_rep(rep_b)
    );

    function automatic int ev_key(input ev_t e);
        return e.cyc * 64 + e.dut * 16 + e.ch * 4 + e.kind;
    endfunction

    // Keep the queue sorted in the order the monitor observes strobes.
    task automatic push_ev(input int c, input int d, input int ch, input int k);
        ev_t e;
        int  i;
        e.cyc  = c;
        e.dut  = d;
        e.ch   = ch;
        e.kind = k;
        i = 0;
        while (i < exp_q.size() && ev_key(exp_q[i]) <= ev_key(e)) i++;
        exp_q.insert(i, e);
    endtask

    // Press at p, repeats every period strictly before release commit q, release at q.
    task automatic push_hold(input int d, input int ch, input int p, input int q, input int period);
        push_ev(p, d, ch, K_PRESS);
        if (period > 0) begin
            for (int t = p + period; t < q; t += period) push_ev(t, d, ch, K_REP);
        end
        push_ev(q, d, ch, K_REL);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        logic [3:0] obs [2][3];
        ev_t        e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_strobe: dut %0d ch %0d kind %0d due cycle %0d, not seen by cycle %0d",
                     exp_q[0].dut, exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        obs[0][0] = press_a;
        obs[0][1] = rel_a;
        obs[0][2] = rep_a;
        obs[1][0] = {3'b000, press_b};
        obs[1][1] = {3'b000, rel_b};
        obs[1][2] = {3'b000, rep_b};
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 4; ch++) begin
                for (int k = 0; k < 3; k++) begin
                    if (obs[d][k][ch]) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_strobe: dut %0d ch %0d kind %0d at cycle %0d, none expected",
                                     d, ch, k, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.cyc != cyc || e.dut != d || e.ch != ch || e.kind != k) begin
                                failures++;
                                $display("FAIL strobe_match: got dut %0d ch %0d kind %0d cycle %0d, expected dut %0d ch %0d kind %0d cycle %0d",
                                         d, ch, k, cyc, e.dut, e.ch, e.kind, e.cyc);
                            end
                        end
                    end
                end
            end
            check("press_release_exclusive", int'(obs[d][0] & obs[d][1]), 0);
        end
    end

    initial begin : stimulus
        int c;
        int c2;

        // Reset state, with the active-low pin idle (high) through reset.
        tick(3);
        check("reset_key_o_a", int'(key_o_a), 0);
        check("reset_press_a", int'(press_a), 0);
        check("reset_rep_a",   int'(rep_a), 0);
        check("reset_key_o_b", int'(key_o_b), 0);
        rst = 1'b0;
        tick(20);
        check("idle_key_o_a", int'(key_o_a), 0);
        check("idle_key_o_b", int'(key_o_b), 0);

        // Ch0 clean press, one repeat, release.
        c = cyc;
        key_a[0] = 1'b1;
        push_hold(0, 0, c + 7, c + 19, REP_P);
        tick(6);
        check("ch0_before_commit", int'(key_o_a), 0);
        tick(1);
        check("ch0_commit", int'(key_o_a), 1);
        tick(5);
        key_a[0] = 1'b0;
        tick(6);
        check("ch0_still_held", int'(key_o_a), 1);
        tick(1);
        check("ch0_released", int'(key_o_a), 0);
        tick(4);

        // Ch1 3-cycle glitch never commits.
        key_a[1] = 1'b1;
        tick(3);
        key_a[1] = 1'b0;
        tick(12);
        check("ch1_glitch_level", int'(key_o_a), 0);

        // Ch1 bounce 1,1,0,1... commits 4 stable samples after the last edge.
        c = cyc;
        push_hold(0, 1, c + 10, c + 30, REP_P);
        key_a[1] = 1'b1;
        tick(2);
        key_a[1] = 1'b0;
        tick(1);
        key_a[1] = 1'b1;
        tick(6);
        check("ch1_bounce_pending", int'(key_o_a), 0);
        tick(1);
        check("ch1_bounce_commit", int'(key_o_a), 2);
        tick(13);
        key_a[1] = 1'b0;
        tick(11);
        check("ch1_released", int'(key_o_a), 0);

        // Ch2 held 30 cycles after commit: repeats at +8, +16, +24.
        c = cyc;
        key_a[2] = 1'b1;
        push_hold(0, 2, c + 7, c + 37, REP_P);
        tick(20);
        check("ch2_held", int'(key_o_a), 4);
        tick(10);
        key_a[2] = 1'b0;
        tick(14);
        check("ch2_released", int'(key_o_a), 0);

        // Active-low channel: drive pin low to press.
        c = cyc;
        key_b = 1'b0;
        push_hold(1, 0, c + 7, c + 17, 0);
        tick(7);
        check("al_pressed", int'(key_o_b), 1);
        tick(3);
        key_b = 1'b1;
        tick(10);
        check("al_released", int'(key_o_b), 0);

        // Reset while ch0 held and ch3 mid-window (cnt==2).
        c = cyc;
        key_a[0] = 1'b1;
        push_ev(c + 7, 0, 0, K_PRESS);
        push_ev(c + 15, 0, 0, K_REP);
        tick(12);
        key_a[3] = 1'b1;
        tick(5);
        rst = 1'b1;
        #1;
        check("midrst_key_o_a", int'(key_o_a), 0);
        check("midrst_press_a", int'(press_a), 0);
        check("midrst_rel_a",   int'(rel_a), 0);
        check("midrst_rep_a",   int'(rep_a), 0);
        tick(3);
        rst = 1'b0;
        c2 = cyc;
        push_hold(0, 0, c2 + 7, c2 + 34, REP_P);
        push_hold(0, 3, c2 + 7, c2 + 34, REP_P);
        tick(6);
        check("post_rst_pending", int'(key_o_a), 0);
        tick(1);
        check("post_rst_commit", int'(key_o_a), 9);
        tick(20);
        key_a = 4'b0000;
        tick(12);
        check("post_rst_released", int'(key_o_a), 0);
        tick(5);

        while (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL pending_strobe: dut %0d ch %0d kind %0d due cycle %0d never seen",
                     exp_q[0].dut, exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
